// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: CPU (m0) vs debug/loader (m1), registered read data.
// Define DM_ARB_RR_EN for round-robin; default is m0 priority with starvation guard.
module dm_arbiter #(
   parameter int AW         = 7,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          dm_we,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_din,
   input  logic [DW-1:0] dm_dout
);

   logic          m1_wins;
   logic          gnt0, gnt1;
   logic          m0_rvalid_q, m0_rvalid_d;
   logic          m1_rvalid_q, m1_rvalid_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;

`ifdef DM_ARB_RR_EN
   logic last_gnt_q, last_gnt_d;

   assign m1_wins = ~last_gnt_q;

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (gnt1)
         last_gnt_d = 1'b1;
      else if (gnt0)
         last_gnt_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         last_gnt_q <= 1'b1;
      else
         last_gnt_q <= last_gnt_d;
   end
`else
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   assign m1_wins = (starve_cnt_q == SW'(STARVE_MAX));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!m1_req || gnt1)
         starve_cnt_d = '0;
      else if (starve_cnt_q != SW'(STARVE_MAX))
         starve_cnt_d = starve_cnt_q + SW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         starve_cnt_q <= '0;
      else
         starve_cnt_q <= starve_cnt_d;
   end
`endif

   // rstn gates grants so no dm write can slip through while in reset
   assign gnt0 = rstn & m0_req & ~(m1_req & m1_wins);
   assign gnt1 = rstn & m1_req & (~m0_req | m1_wins);

   assign m0_gnt  = gnt0;
   assign m1_gnt  = gnt1;
   assign dm_addr = gnt1 ? m1_addr  : m0_addr;
   assign dm_din  = gnt1 ? m1_wdata : m0_wdata;
   assign dm_we   = gnt1 ? m1_we    : (gnt0 & m0_we);

   always_comb begin
      m0_rvalid_d = gnt0 & ~m0_we;
      m1_rvalid_d = gnt1 & ~m1_we;
      m0_rdata_d  = m0_rvalid_d ? dm_dout : m0_rdata_q;
      m1_rdata_d  = m1_rvalid_d ? dm_dout : m1_rdata_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: shadow-memory reference model plus directed literal checks.
// Honors DM_ARB_RR_EN the same way as the design.
module tb_dm_arbiter;

   localparam int AW = 7;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_din, dm_dout;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din),
      .dm_dout(dm_dout)
   );

   // the dm block itself: synchronous write, combinational read
   logic [DW-1:0] mem [128];
   assign dm_dout = mem[dm_addr];
   always @(posedge clk)
      if (dm_we) mem[dm_addr] <= dm_din;

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model state, as seen after the coming rising edge
   logic [DW-1:0] mmem [128];
   int            starve;
   bit            last;
   bit            rv0, rv1;
   logic [DW-1:0] rd0, rd1;

   always @(negedge clk) begin
      bit e0, e1, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (!rstn) begin
         starve = 0; last = 1; rv0 = 0; rv1 = 0; rd0 = '0; rd1 = '0;
      end
      e0 = 0; e1 = 0;
      if (rstn) begin
         if (m0_req && !m1_req) e0 = 1;
         else if (m1_req && !m0_req) e1 = 1;
         else if (m0_req && m1_req) begin
`ifdef DM_ARB_RR_EN
            if (last) e0 = 1; else e1 = 1;
`else
            if (starve == SM) e1 = 1; else e0 = 1;
`endif
         end
      end
      ea  = e1 ? m1_addr : m0_addr;
      ed  = e1 ? m1_wdata : m0_wdata;
      ewe = (e0 && m0_we) || (e1 && m1_we);
      chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, e0});
      chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, e1});
      chk("dm_we", {31'b0, dm_we}, {31'b0, ewe});
      chk("dm_addr", {25'b0, dm_addr}, {25'b0, ea});
      chk("dm_din", dm_din, ed);
      chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, rv0});
      chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, rv1});
      chk("m0_rdata", m0_rdata, rd0);
      chk("m1_rdata", m1_rdata, rd1);
      if (rstn) begin
         rv0 = e0 && !m0_we;
         rv1 = e1 && !m1_we;
         if (rv0) rd0 = mmem[m0_addr];
         if (rv1) rd1 = mmem[m1_addr];
         if (!m1_req || e1) starve = 0;
         else if (starve < SM) starve++;
         if (e0) last = 0;
         if (e1) last = 1;
         if (ewe) mmem[ea] = ed;
      end
   end

   task automatic drive(input bit r0, input bit w0, input int a0,
                        input logic [DW-1:0] d0, input bit r1,
                        input bit w1, input int a1,
                        input logic [DW-1:0] d1);
      @(posedge clk); #1;
      m0_req = r0; m0_we = w0; m0_addr = AW'(a0); m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = AW'(a1); m1_wdata = d1;
   endtask

   task automatic sample;
      @(negedge clk); #1;
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   bit pat [10];
   bit exp_pat [10];

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i]  = '0;
         mmem[i] = '0;
      end
      rstn = 1'b0;
      m0_req = 1; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1; m1_we = 0; m1_addr = 7'd3; m1_wdata = '0;
      sample;
      chk("rst m0_gnt", {31'b0, m0_gnt}, 32'd0);
      chk("rst m1_gnt", {31'b0, m1_gnt}, 32'd0);
      chk("rst dm_we", {31'b0, dm_we}, 32'd0);
      chk("rst m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
      chk("rst m1_rdata", m1_rdata, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      m0_req = 0; m1_req = 1; m1_we = 1; m1_addr = 7'd5;
      m1_wdata = 32'hDEADBEEF;
      sample;
      chk("wr5 m1_gnt", {31'b0, m1_gnt}, 32'd1);
      chk("wr5 dm_we", {31'b0, dm_we}, 32'd1);
      drive(1, 0, 5, 0, 0, 0, 0, 0);
      sample;
      chk("rd5 m0_gnt", {31'b0, m0_gnt}, 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      sample;
      chk("rd5 m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
      chk("rd5 m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk("rd5 m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
      drive(1, 1, 127, 32'h1, 0, 0, 0, 0);
      sample;
      chk("rd5 pulse end", {31'b0, m0_rvalid}, 32'd0);
      drive(1, 0, 127, 32'h0, 0, 0, 0, 0);
      sample;
      chk("rd127 dm_we", {31'b0, dm_we}, 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      sample;
      chk("rd127 m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
      chk("rd127 m0_rdata", m0_rdata, 32'h1);

      do_reset;
      m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0;
      for (int i = 0; i < 10; i++) begin
         sample;
         pat[i] = m1_gnt;
         @(posedge clk); #1;
      end
`ifdef DM_ARB_RR_EN
      for (int i = 0; i < 10; i++) exp_pat[i] = (i % 2 == 1);
`else
      for (int i = 0; i < 10; i++) exp_pat[i] = (i % 5 == 4);
`endif
      for (int i = 0; i < 10; i++)
         chk($sformatf("pattern[%0d]", i), {31'b0, pat[i]},
             {31'b0, exp_pat[i]});

      drive(1, 0, 5, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rstn = 1'b0;
      m0_req = 0;
      sample;
      chk("rstrd m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
      chk("rstrd m0_rdata", m0_rdata, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         int a0, a1;
         a0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                          : $urandom_range(120, 127);
         a1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                          : $urandom_range(120, 127);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a0,
               $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, a1, $urandom);
         rstn = ($urandom_range(0, 199) != 0);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      m0_req = 0; m1_req = 0;
      repeat (3) @(posedge clk);
      sample;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
